mode_sequencer: RTL
===================

MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 Parameter CLK_PER_STEP, default 12_500_000; clocks per pattern step tick, legal range >= 2.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500_000; consecutive stable synchronised-high cycles that qualify a button press, legal range >= 1.
REQ-003 Parameter STEPS_PER_MODE, default 16; ticks spent in a mode before auto-advance, legal range >= 1.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-006 btn  input  1  raw, asynchronous, active-high mode button.
REQ-007 auto  input  1  auto-cycle request, level-sensitive, synchronous to clk.
REQ-008 en  output  4  one-hot enable to the four LED pattern stages (bit n = mode n).
REQ-009 mode  output  2  current mode index 0..3.
REQ-010 tick  output  1  one-cycle step strobe for the enabled pattern stage.
REQ-011 mode_chg  output  1  one-cycle pulse marking a mode transition.

Function
REQ-012 btn shall pass through a 2-flop synchroniser before any other use.
REQ-013 A press shall be qualified once the synchronised btn has been high for DEBOUNCE_CYCLES consecutive cycles; any low sample clears the debounce count.
REQ-014 A qualified press shall generate exactly one advance request, and no further request until the synchronised btn has been low for DEBOUNCE_CYCLES consecutive cycles (release debounce).
REQ-015 Debounce FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-016 Debounce FSM transitions: IDLE->PRESS_WAIT on high; PRESS_WAIT->HELD on count reached, emitting the request; PRESS_WAIT->IDLE on low; HELD->RELEASE_WAIT on low; RELEASE_WAIT->IDLE on count reached; RELEASE_WAIT->HELD on high.
REQ-017 Latency: mode shall update on the rising edge DEBOUNCE_CYCLES+2 edges after the first edge that samples btn high.
REQ-018 An advance shall set mode to (mode+1) mod 4, wrapping 3->0.
REQ-019 On each advance, mode_chg shall be 1 for exactly the following cycle; en shall be 4'b0000 in that cycle, then the new one-hot value from the next cycle on.
REQ-020 The prescaler shall count 0..CLK_PER_STEP-1 while en is nonzero; tick shall be 1 in the cycle the count equals CLK_PER_STEP-1, then the count wraps to 0.
REQ-021 On an advance, the prescaler and the step counter shall both clear; the first tick in the new mode comes CLK_PER_STEP cycles after en is reasserted.
REQ-022 While auto=1, the step counter shall count ticks and request an advance on the STEPS_PER_MODE-th tick.
REQ-023 While auto=0, the step counter shall hold at 0.
REQ-024 If a button request and an auto request occur in the same cycle, the block shall advance once only.
REQ-025 Requests arriving during the mode_chg cycle shall be dropped.

Reset
REQ-026 On reset=0 at a clk edge: mode=0, en=4'b0001, tick=0, mode_chg=0, prescaler=0, step counter=0, debounce FSM=IDLE with count 0, synchroniser flops=0.
REQ-027 Reset asserted mid-transition or mid-debounce shall abandon the transition or debounce with no pending advance; the held-button state is not remembered.

Configuration
REQ-028 With macro MODE_SEQ_AUTO_EN defined, the auto-advance logic of REQ-022..REQ-024 shall be present.
REQ-029 With MODE_SEQ_AUTO_EN undefined, the step counter shall be absent, auto shall be ignored, and modes shall change only on button presses; all other behaviour is identical.

Structure
REQ-030 Shared package mode_seq_pkg shall hold: the mode typedef (2-bit, MODE0..MODE3), the one-hot enable constants EN_MODE0..EN_MODE3, and the debounce state typedef.
REQ-031 The synchroniser and debounce FSM shall be a sub-module, btn_debounce, with a single-cycle press_req output.

Verification (CLK_PER_STEP=4, DEBOUNCE_CYCLES=3, STEPS_PER_MODE=5)
REQ-032 Reset then idle 20 cycles -> mode=0, en=0001, tick every 4th cycle with first tick at cycle 4, mode_chg never 1.
REQ-033 btn held high 10 cycles, auto=0 -> single mode_chg 5 edges after first high sample; en=0000 for 1 cycle, then 0010; mode=1; holding btn causes no second advance.
REQ-034 btn glitch high 2 cycles, low, high 2 cycles -> no advance; mode stays 0.
REQ-035 Four qualified presses with release -> mode sequence 1,2,3,0; en ends at 0001 (wrap).
REQ-036 auto=1 -> advance on every 5th tick (mode holds 20 active cycles); a press qualified in the same cycle as the 5th tick -> one advance only.
REQ-037 reset=0 pulse in the mode_chg cycle -> next cycle mode=0, en=0001, mode_chg=0; build without MODE_SEQ_AUTO_EN, auto=1 for 100 cycles -> mode stays 0.

Source files
------------

// File: rtl/mode_seq_pkg.sv
// Shared types and constants for the LED mode sequencer: mode index, one-hot
// stage enables and the button debounce state encoding.
package mode_seq_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } mode_t;

    localparam logic [3:0] EN_MODE0 = 4'b0001;
    localparam logic [3:0] EN_MODE1 = 4'b0010;
    localparam logic [3:0] EN_MODE2 = 4'b0100;
    localparam logic [3:0] EN_MODE3 = 4'b1000;
    localparam logic [3:0] EN_NONE  = 4'b0000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    function automatic logic [3:0] mode_to_en(input mode_t m);
        logic [3:0] onehot;
        onehot = EN_MODE0;
        case (m)
            MODE0:   onehot = EN_MODE0;
            MODE1:   onehot = EN_MODE1;
            MODE2:   onehot = EN_MODE2;
            MODE3:   onehot = EN_MODE3;
            default: onehot = EN_MODE0;
        endcase
        return onehot;
    endfunction

    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus press/release debounce; emits one registered
// press_req pulse per qualified press and ignores the button until released.
module btn_debounce
    import mode_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press_req
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam bit              SINGLE   = (DEBOUNCE_CYCLES == 1);

    logic            sync1;
    logic            sync2;
    db_state_t       state;
    db_state_t       state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            req_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            press_req <= 1'b0;
        end else begin
            sync1     <= btn;
            sync2     <= sync1;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            press_req <= req_nxt;
        end
    end

    // The count holds the number of consecutive samples already seen at the
    // level being qualified, so the terminal sample is the one at CNT_LAST.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_nxt   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (sync2) begin
                    if (SINGLE) begin
                        state_nxt = HELD;
                        req_nxt   = 1'b1;
                    end else begin
                        state_nxt = PRESS_WAIT;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!sync2) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    req_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HELD: begin
                cnt_nxt = '0;
                if (!sync2) begin
                    if (SINGLE) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RELEASE_WAIT;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (sync2) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/mode_sequencer.sv
// Four-mode LED pattern sequencer: debounced button advance, step prescaler,
// and optional auto-advance after STEPS_PER_MODE ticks (macro MODE_SEQ_AUTO_EN).
module mode_sequencer
    import mode_seq_pkg::*;
#(
    parameter int CLK_PER_STEP    = 12_500_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int STEPS_PER_MODE  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       auto,
    output logic [3:0] en,
    output logic [1:0] mode,
    output logic       tick,
    output logic       mode_chg
);

    localparam int            PW         = $clog2(CLK_PER_STEP);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_STEP - 1);

    logic          press_req;
    logic          auto_req;
    logic          advance;
    mode_t         mode_q;
    logic [PW-1:0] presc;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn),
        .press_req(press_req)
    );

`ifdef MODE_SEQ_AUTO_EN
    localparam int            SW        = (STEPS_PER_MODE > 1) ? $clog2(STEPS_PER_MODE) : 1;
    localparam logic [SW-1:0] STEP_ONE  = SW'(1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS_PER_MODE - 1);

    logic [SW-1:0] step;

    always_ff @(posedge clk) begin
        if (!reset || advance || !auto) begin
            step <= '0;
        end else if (tick) begin
            step <= step + STEP_ONE;
        end
    end

    assign auto_req = auto && tick && (step == STEP_LAST);
`else
    logic unused_auto;

    assign unused_auto = auto;
    assign auto_req    = 1'b0;
`endif

    // Coincident button and auto requests merge into one advance; anything
    // landing in the blanking cycle is discarded rather than queued.
    always_comb begin
        advance = (press_req || auto_req) && !mode_chg;
        tick    = (en != EN_NONE) && (presc == PRESC_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q   <= MODE0;
            en       <= EN_MODE0;
            mode_chg <= 1'b0;
            presc    <= '0;
        end else begin
            mode_chg <= advance;
            if (advance) begin
                mode_q <= next_mode(mode_q);
                en     <= EN_NONE;
                presc  <= '0;
            end else begin
                en <= mode_to_en(mode_q);
                if (en != EN_NONE) begin
                    presc <= tick ? '0 : (presc + PRESC_ONE);
                end
            end
        end
    end

    assign mode = mode_q;

endmodule
